// File: rtl/stepper_move_sequencer.sv
// Queued step/dir move controller: a command FIFO feeds a pulse generator that
// guarantees step-high width, minimum period and dir setup time after reversal.
module stepper_move_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int PER_W      = 16,
  parameter int PULSE_W    = 8,
  parameter int DIR_SETUP  = 16,
  parameter int POS_W      = 32
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           enable,
  input  logic                           abort,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_dir,
  input  logic [CNT_W-1:0]               cmd_steps,
  input  logic [PER_W-1:0]               cmd_period,
  output logic                           step,
  output logic                           dir,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic signed [POS_W-1:0]        position,
  output logic                           move_done,
  output logic                           aborted
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int SW  = $clog2(DIR_SETUP + 1);
  localparam int PW  = $clog2(PULSE_W + 2);
  localparam int CW0 = (PER_W > SW) ? PER_W : SW;
  localparam int CW  = (CW0 > PW) ? CW0 : PW;

  localparam logic [CW-1:0] MIN_P    = CW'(PULSE_W + 1);
  localparam logic [CW-1:0] PULSE_M1 = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETUP_M1 = CW'(DIR_SETUP - 1);

  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [PER_W-1:0] period;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, FLUSH} state_t;

  cmd_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              ready_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  cmd_t              head;
  logic [CW-1:0]     head_per;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [CW-1:0]     per;
  logic [CW-1:0]     per_nx;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  rem_nx;
  logic              ndir;
  logic              ndir_nx;
  logic              step_nx;
  logic              dir_nx;
  logic              abort_pend;
  logic              abort_pend_nx;
  logic signed [POS_W-1:0] pos_nx;

  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign cmd_ready  = ready_q && !full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign fifo_level = level;
  assign busy       = (state != IDLE) || !empty;
  assign head       = mem[rd_ptr];
  assign head_per   = (CW'(head.period) < MIN_P) ? MIN_P : CW'(head.period);

  // ready_q holds cmd_ready low until the first edge after reset release
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= '{dir: cmd_dir, steps: cmd_steps, period: cmd_period};
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    per_nx        = per;
    rem_nx        = rem;
    ndir_nx       = ndir;
    step_nx       = step;
    dir_nx        = dir;
    pos_nx        = position;
    abort_pend_nx = abort_pend;
    pop           = 1'b0;
    move_done     = 1'b0;
    aborted       = 1'b0;

    case (state)
      IDLE: begin
        if (abort) begin
          state_nx = FLUSH;
        end else if (enable && !empty) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = FLUSH;
        end else if (rem == '0) begin
          move_done = 1'b1;
          state_nx  = IDLE;
        end else if (ndir != dir) begin
          dir_nx   = ndir;
          cnt_nx   = SETUP_M1;
          state_nx = SETUP;
        end else begin
          step_nx  = 1'b1;
          cnt_nx   = PULSE_M1;
          rem_nx   = rem - 1'b1;
          pos_nx   = dir ? position + POS_W'(1) : position - POS_W'(1);
          state_nx = HIGH;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nx = FLUSH;
        end else if (cnt == '0) begin
          step_nx  = 1'b1;
          cnt_nx   = PULSE_M1;
          rem_nx   = rem - 1'b1;
          pos_nx   = dir ? position + POS_W'(1) : position - POS_W'(1);
          state_nx = HIGH;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      // an abort seen mid-pulse is remembered so the pulse keeps its full width
      HIGH: begin
        if (abort) abort_pend_nx = 1'b1;
        if (cnt == '0) begin
          step_nx = 1'b0;
          if (abort || abort_pend) begin
            abort_pend_nx = 1'b0;
            state_nx      = FLUSH;
          end else begin
            cnt_nx   = per - MIN_P;
            state_nx = LOW;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_nx = FLUSH;
        end else if (cnt == '0) begin
          if (rem != '0) begin
            step_nx  = 1'b1;
            cnt_nx   = PULSE_M1;
            rem_nx   = rem - 1'b1;
            pos_nx   = dir ? position + POS_W'(1) : position - POS_W'(1);
            state_nx = HIGH;
          end else begin
            move_done = 1'b1;
            if (enable && !empty) begin
              pop      = 1'b1;
              state_nx = LOAD;
            end else begin
              state_nx = IDLE;
            end
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      FLUSH: begin
        aborted  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // the head entry is captured as it leaves the FIFO and evaluated in LOAD
    if (pop) begin
      per_nx  = head_per;
      rem_nx  = head.steps;
      ndir_nx = head.dir;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      per        <= '0;
      rem        <= '0;
      ndir       <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      position   <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      per        <= per_nx;
      rem        <= rem_nx;
      ndir       <= ndir_nx;
      step       <= step_nx;
      dir        <= dir_nx;
      position   <= pos_nx;
      abort_pend <= abort_pend_nx;
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer: a table of single moves with
// hand-computed timing/position, then reversal, FIFO-full, abort and reset cases.
module tb_stepper_move_sequencer;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        enable;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        step;
  logic        dir;
  logic        busy;
  logic [2:0]  fifo_level;
  logic signed [31:0] position;
  logic        move_done;
  logic        aborted;

  stepper_move_sequencer #(
    .FIFO_DEPTH(4),
    .CNT_W(16),
    .PER_W(16),
    .PULSE_W(8),
    .DIR_SETUP(16),
    .POS_W(32)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable(enable),
    .abort(abort),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_period(cmd_period),
    .step(step),
    .dir(dir),
    .busy(busy),
    .fifo_level(fifo_level),
    .position(position),
    .move_done(move_done),
    .aborted(aborted)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_q[$];
  int width_q[$];
  int done_n   = 0;
  int abort_n  = 0;
  int done_cyc = -1;
  int dir_chg  = -1;
  logic step_d = 1'b0;
  logic dir_d  = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (step && !step_d) rise_q.push_back(cyc);
    if (!step && step_d && rise_q.size() > 0) width_q.push_back(cyc - rise_q[$]);
    if (move_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (aborted) abort_n++;
    if (dir != dir_d) dir_chg = cyc;
    step_d = step;
    dir_d  = dir;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input int s, input int p, output int edge_cyc);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = 16'(s);
    cmd_period = 16'(p);
    @(posedge sys_clk);
    #1;
    edge_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sys_clk);
      #1;
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    if (idle_cyc < 0) check("idle_timeout", busy, 0);
  endtask

  task automatic clear_mon();
    rise_q.delete();
    width_q.delete();
    done_n  = 0;
    abort_n = 0;
  endtask

  typedef struct {
    logic d;
    int   steps;
    int   period;
    int   exp_p;
    int   exp_lat;
    int   exp_pos;
  } vec_t;

  vec_t vt [6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe, ic, pe2, exp_pos, exp_done;

    // dir resets to 0, so the first positive move and later sign flips incur setup
    vt[0] = '{d: 1'b1, steps: 3, period: 20,  exp_p: 20,  exp_lat: 18, exp_pos: 3};
    vt[1] = '{d: 1'b1, steps: 2, period: 4,   exp_p: 9,   exp_lat: 2,  exp_pos: 5};
    vt[2] = '{d: 1'b1, steps: 0, period: 20,  exp_p: 20,  exp_lat: 2,  exp_pos: 5};
    vt[3] = '{d: 1'b0, steps: 2, period: 9,   exp_p: 9,   exp_lat: 18, exp_pos: 3};
    vt[4] = '{d: 1'b0, steps: 1, period: 100, exp_p: 100, exp_lat: 2,  exp_pos: 2};
    vt[5] = '{d: 1'b0, steps: 4, period: 10,  exp_p: 10,  exp_lat: 2,  exp_pos: -2};

    sys_rst_n  = 1'b0;
    enable     = 1'b1;
    abort      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;

    #12;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_pos", position, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", move_done, 0);
    check("rst_aborted", aborted, 0);
    #10 sys_rst_n = 1'b1;
    #1 check("ready_before_edge", cmd_ready, 0);
    @(posedge sys_clk);
    #1 check("ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      push(vt[i].d, vt[i].steps, vt[i].period, pe);
      wait_idle(3000, ic);
      check($sformatf("v%0d_pulses", i), rise_q.size(), vt[i].steps);
      check($sformatf("v%0d_falls", i), width_q.size(), vt[i].steps);
      if (rise_q.size() > 0) check($sformatf("v%0d_latency", i), rise_q[0] - pe, vt[i].exp_lat);
      foreach (width_q[k]) check($sformatf("v%0d_width%0d", i, k), width_q[k], 8);
      for (int k = 1; k < rise_q.size(); k++)
        check($sformatf("v%0d_period%0d", i, k), rise_q[k] - rise_q[k-1], vt[i].exp_p);
      check($sformatf("v%0d_position", i), position, vt[i].exp_pos);
      check($sformatf("v%0d_done_count", i), done_n, 1);
      exp_done = (vt[i].steps == 0) ? pe + 1 : pe + vt[i].exp_lat + vt[i].steps * vt[i].exp_p - 1;
      check($sformatf("v%0d_done_cycle", i), done_cyc, exp_done);
      check($sformatf("v%0d_busy_fall", i), ic, exp_done + 1);
    end
    exp_pos = -2;

    // reversal: +2 then -2 queued back to back
    clear_mon();
    push(1'b1, 2, 20, pe);
    push(1'b0, 2, 20, pe2);
    wait_idle(3000, ic);
    check("rev_pulses", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      check("rev_pos_period", rise_q[1] - rise_q[0], 20);
      check("rev_gap", rise_q[2] - rise_q[1], 37);
      check("rev_setup", rise_q[2] - dir_chg, 16);
    end
    check("rev_dir", dir, 0);
    check("rev_position", position, exp_pos);
    check("rev_done_count", done_n, 2);

    // fill the FIFO with enable low, then drain back to back
    clear_mon();
    enable = 1'b0;
    push(1'b1, 1, 12, pe);
    push(1'b1, 1, 12, pe);
    check("full_level2", fifo_level, 2);
    push(1'b1, 1, 12, pe);
    push(1'b1, 1, 12, pe);
    check("full_ready", cmd_ready, 0);
    check("full_level4", fifo_level, 4);
    check("full_busy", busy, 1);
    check("full_no_step", rise_q.size(), 0);
    enable = 1'b1;
    wait_idle(3000, ic);
    check("full_pulses", rise_q.size(), 4);
    for (int k = 1; k < rise_q.size(); k++)
      check($sformatf("full_gap%0d", k), rise_q[k] - rise_q[k-1], 13);
    exp_pos = exp_pos + 4;
    check("full_position", position, exp_pos);
    check("full_done_count", done_n, 4);

    // abort three cycles into the second pulse of a 10-step move, 2 queued
    clear_mon();
    enable = 1'b0;
    push(1'b1, 10, 20, pe);
    push(1'b1, 5, 20, pe);
    push(1'b1, 5, 20, pe);
    enable = 1'b1;
    for (int i = 0; i < 200 && rise_q.size() < 2; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("abort_reach_step2", rise_q.size(), 2);
    check("abort_level_before", fifo_level, 2);
    @(posedge sys_clk);
    #1;
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd3;
    cmd_period = 16'd20;
    #1 check("abort_ready_low", cmd_ready, 0);
    @(posedge sys_clk);
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abort_level_after", fifo_level, 0);
    check("abort_step_held", step, 1);
    wait_idle(200, ic);
    check("abort_pulses", rise_q.size(), 2);
    check("abort_falls", width_q.size(), 2);
    if (width_q.size() == 2) check("abort_width", width_q[1], 8);
    check("abort_pulse_count", abort_n, 1);
    check("abort_no_done", done_n, 0);
    exp_pos = exp_pos + 2;
    check("abort_position", position, exp_pos);
    check("abort_level_idle", fifo_level, 0);

    // asynchronous reset in the LOW phase of an active move
    clear_mon();
    push(1'b1, 3, 20, pe);
    for (int i = 0; i < 200 && width_q.size() < 1; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("reset_reach_low", width_q.size(), 1);
    @(posedge sys_clk);
    #1;
    check("reset_pre_pos", position, exp_pos + 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("areset_step", step, 0);
    check("areset_dir", dir, 0);
    check("areset_busy", busy, 0);
    check("areset_pos", position, 0);
    check("areset_level", fifo_level, 0);
    check("areset_ready", cmd_ready, 0);
    check("areset_done", move_done, 0);
    #13 sys_rst_n = 1'b1;
    #1 check("areset_ready_before_edge", cmd_ready, 0);
    @(posedge sys_clk);
    #1 check("areset_ready_after", cmd_ready, 1);
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("areset_no_spurious_step", rise_q.size(), 1);
    check("areset_pos_hold", position, 0);
    check("areset_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
